// File: rtl/data_memory_pipe.sv
// data_memory_pipe: configurable-depth data memory for the 19-bit datapath.
// Requests use a valid/ready handshake. Reads come back through an
// RD_LAT-deep pipeline with response backpressure. Out-of-range accesses
// are flagged, and an 8-bit saturating counter tracks erroneous accesses.
// Optional feature macro: DMEM_PARITY_EN. When it is defined, each word
// stores an even-parity bit that is checked on read.
module data_memory_pipe #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        err_count
);

`ifdef DMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [MEM_W-1:0]  mem [DEPTH];

    logic              advance;
    logic              acc;
    logic              rd_acc;
    logic              wr_acc;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  wr_word;
    logic              par_bad;
    logic [DATA_W-1:0] s0_data;
    logic              s0_err;
    logic              s0_perr;
    logic              oor_evt;
    logic              par_evt;
    logic [8:0]        err_sum;

    logic [RD_LAT-1:0] st_vld;
    logic [RD_LAT-1:0] st_err;
    logic [RD_LAT-1:0] st_perr;
    logic [DATA_W-1:0] st_data [RD_LAT];

    // The whole pipeline moves only when the output slot is free or being drained.
    assign advance   = !rsp_valid || rsp_ready;
    assign req_ready = advance;
    assign acc       = req_valid && advance;
    assign rd_acc    = acc && !req_we;
    assign wr_acc    = acc && req_we;
    assign in_range  = {1'b0, req_addr} < DEPTH_L;
    assign idx       = req_addr[IDX_W-1:0];

    assign rsp_valid = st_vld[RD_LAT-1];
    assign rsp_rdata = st_data[RD_LAT-1];
    assign rsp_err   = st_err[RD_LAT-1];

    // Array lookup, parity check and the stage-1 payload for the current request.
    always_comb begin
        rd_word = mem[idx];
`ifdef DMEM_PARITY_EN
        wr_word = {^req_wdata, req_wdata};
        par_bad = ^rd_word;
`else
        wr_word = req_wdata;
        par_bad = 1'b0;
`endif
        s0_data = '0;
        s0_err  = 1'b1;
        s0_perr = 1'b0;
        if (in_range) begin
            s0_data = rd_word[DATA_W-1:0];
            s0_err  = par_bad;
            s0_perr = par_bad;
        end
    end

    // Storage: in-range accepted writes only; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            mem[idx] <= wr_word;
        end
    end

    // Read pipeline: shifts on advance; bubbles move only the valid bit so data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_vld  <= '0;
            st_err  <= '0;
            st_perr <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                st_data[i] <= '0;
            end
        end else if (advance) begin
            st_vld[0] <= rd_acc;
            if (rd_acc) begin
                st_data[0] <= s0_data;
                st_err[0]  <= s0_err;
                st_perr[0] <= s0_perr;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                st_vld[i] <= st_vld[i-1];
                if (st_vld[i-1]) begin
                    st_data[i] <= st_data[i-1];
                    st_err[i]  <= st_err[i-1];
                    st_perr[i] <= st_perr[i-1];
                end
            end
        end
    end

    // Error events this cycle: an out-of-range acceptance plus a parity-bad response handshake.
    always_comb begin
        oor_evt = acc && !in_range;
        par_evt = rsp_valid && rsp_ready && st_perr[RD_LAT-1];
        err_sum = 9'(err_count) + 9'(oor_evt) + 9'(par_evt);
    end

    // Saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_sum > 9'd255) begin
            err_count <= 8'd255;
        end else begin
            err_count <= err_sum[7:0];
        end
    end

endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: scoreboard bench for data_memory_pipe with DEPTH=1000 and RD_LAT=2.
// Stimulus pushes expected read responses; a monitor pops them on each response handshake.
module tb_data_memory_pipe;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [7:0]        err_count;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [19:0] expq[$];
    logic [19:0] exp_word;

    data_memory_pipe #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .err_count(err_count)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report it if it differs from the expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present one request from a negedge and hold it until accepted. Expected read data is queued.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata,
                                 input logic [DATA_W-1:0] exp_data, input logic exp_err);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        for (int guard = 0; guard < 100; guard++) begin
            #1;
            if (req_ready) begin
                if (!we) expq.push_back({exp_err, exp_data});
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checkOutput("accept_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    // Monitor: on every response handshake, pop the oldest expectation and compare against it.
    always @(negedge clk) begin
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_rsp: got rdata %0h err %0b, expected no response", rsp_rdata, rsp_err);
            end else begin
                exp_word = expq.pop_front();
                checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_word[DATA_W-1:0]));
                checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_word[19]});
            end
        end
    end

    // Watchdog: end the run if it ever stops making progress.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two reads in flight, then an asynchronous reset kills them.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'd5;
        @(posedge clk);
        @(negedge clk);
        req_addr = 10'd6;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checkOutput("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        checkOutput("midrst_err_count", 32'(err_count), 32'd0);
        checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // Write then read back; the response appears on the second cycle after acceptance.
        applyStimulus(1'b1, 10'd5, 19'h5A5A5, '0, 1'b0);
        applyStimulus(1'b0, 10'd5, '0, 19'h5A5A5, 1'b0);
        req_valid = 1'b0;
        checkOutput("lat_cycle1_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        checkOutput("lat_cycle2_valid", {31'd0, rsp_valid}, 32'd1);
        repeat (3) @(negedge clk);

        // Backpressure: four back-to-back reads with a three-cycle consumer stall.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 10'(i), 19'(16 + i), '0, 1'b0);
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus(1'b0, 10'(i), '0, 19'(16 + i), 1'b0);
                req_valid = 1'b0;
            end
            begin
                for (int w = 0; w < 20 && !rsp_valid; w++) @(negedge clk);
                checkOutput("bp_first_rsp", {31'd0, rsp_valid}, 32'd1);
                for (int c = 0; c < 3; c++) begin
                    rsp_ready = 1'b0;
                    #1;
                    checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
                    checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                    checkOutput("bp_rdata_hold", 32'(rsp_rdata), 32'h10);
                    @(negedge clk);
                end
                rsp_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);

        // Out-of-range write and read; the neighbouring in-range word is unaffected.
        applyStimulus(1'b1, 10'd999, 19'h7ABCD, '0, 1'b0);
        applyStimulus(1'b1, 10'd1000, 19'h00001, '0, 1'b0);
        applyStimulus(1'b0, 10'd1000, '0, 19'h00000, 1'b1);
        applyStimulus(1'b0, 10'd999, '0, 19'h7ABCD, 1'b0);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("oor_err_count", 32'(err_count), 32'd2);

`ifdef DMEM_PARITY_EN
        // Corrupt the stored parity bit directly in the array.
        applyStimulus(1'b1, 10'd7, 19'h00003, '0, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        dut.mem[7][DATA_W] = ~dut.mem[7][DATA_W];
        applyStimulus(1'b0, 10'd7, '0, 19'h00003, 1'b1);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("par_err_count", 32'(err_count), 32'd3);
`endif

        // Saturation: 300 out-of-range writes drive the counter to 255, where it stays.
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 10'(1000 + (i % 24)), 19'(i), '0, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("sat_err_count", 32'(err_count), 32'd255);
        applyStimulus(1'b0, 10'd1023, '0, 19'h00000, 1'b1);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("sat_hold", 32'(err_count), 32'd255);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
